// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: registered single-cycle ops plus iterative mulu/divu with HI/LO results.
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise divu flags dz with lo=hi=0.
module alu_mc #(
    parameter int unsigned  WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zero,
    output logic             o_dz,
    output logic             o_busy
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_dz;
`ifdef ALU_MC_DIV_EN
    logic             r_div;
    logic [WIDTH:0]   w_div_sh;
`endif

    logic             w_accept;
    logic             w_iter;
    logic [WIDTH-1:0] w_sc_lo;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_dz;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_step_lo;
    logic [WIDTH-1:0] w_step_hi;

    assign o_in_ready  = (r_state == StIdle) || ((r_state == StDone) && i_out_ready);
    assign w_accept    = i_in_valid && o_in_ready;
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state == StBusy);
    assign o_lo        = r_lo;
    assign o_hi        = r_hi;
    assign o_dz        = r_dz;
    assign o_zero      = (r_lo == '0);

    // Result of a request that completes without iterating.
    always_comb begin
        w_sc_lo = '0;
        w_sc_hi = '0;
        w_sc_dz = 1'b0;
        w_iter  = 1'b0;
        case (i_op)
            OP_ADD:  w_sc_lo = i_a + i_b;
            OP_SUB:  w_sc_lo = i_a + ~i_b + WIDTH'(1);
            OP_AND:  w_sc_lo = i_a & i_b;
            OP_OR:   w_sc_lo = i_a | i_b;
            OP_XOR:  w_sc_lo = i_a ^ i_b;
            OP_SLT:  w_sc_lo = WIDTH'($signed(i_a) < $signed(i_b));
            OP_MULU: w_iter = 1'b1;
            OP_DIVU: begin
`ifdef ALU_MC_DIV_EN
                if (i_b == '0) begin
                    w_sc_lo = '1;
                    w_sc_hi = i_a;
                    w_sc_dz = 1'b1;
                end else begin
                    w_iter = 1'b1;
                end
`else
                w_sc_dz = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // One iteration: shift-add multiply step, or restoring divide step on {hi,lo}.
    always_comb begin
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_step_hi = w_mul_sum[WIDTH:1];
        w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        w_div_sh = {r_hi, r_lo[WIDTH-1]};
        if (r_div) begin
            if (w_div_sh >= {1'b0, r_a}) begin
                w_step_hi = w_div_sh[WIDTH-1:0] - r_a;
                w_step_lo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_step_hi = w_div_sh[WIDTH-1:0];
                w_step_lo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_a     <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_dz    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            r_div   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_dz  <= w_sc_dz;
            if (w_iter) begin
                r_state <= StBusy;
                r_hi    <= '0;
`ifdef ALU_MC_DIV_EN
                r_div   <= (i_op == OP_DIVU);
                r_a     <= (i_op == OP_DIVU) ? i_b : i_a;
                r_lo    <= (i_op == OP_DIVU) ? i_a : i_b;
`else
                r_a     <= i_a;
                r_lo    <= i_b;
`endif
            end else begin
                r_state <= StDone;
                r_lo    <= w_sc_lo;
                r_hi    <= w_sc_hi;
            end
        end else if (r_state == StBusy) begin
            r_lo  <= w_step_lo;
            r_hi  <= w_step_hi;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
                r_state <= StDone;
            end
        end else if ((r_state == StDone) && i_out_ready) begin
            r_state <= StIdle;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); divu expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        dz;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic bad_busy;
    logic flag;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_op       (op),
        .i_a        (a),
        .i_b        (b),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_lo       (lo),
        .o_hi       (hi),
        .o_zero     (zero),
        .o_dz       (dz),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble the inputs after accept, wait (bounded) for out_valid.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int l);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~x;
        b = ~y;
        l = 1;
        bad_busy = 1'b0;
        while (!out_valid && l < 200) begin
            if (!busy || in_ready) bad_busy = 1'b1;
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = OP_AND;
        a = '0;
        b = '0;
        #12;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_lo_hi", {hi, lo}, 64'd0);
        check_val("rst_zero_dz_busy", 64'({zero, dz, busy}), 64'b100);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat);
        check_val("add_lat", 64'(lat), 64'd1);
        check_val("add_result", {hi, lo}, 64'd0);
        check_val("add_zero", 64'(zero), 64'd1);

        run_op(OP_SUB, 32'd5, 32'd7, lat);
        check_val("sub_lo", 64'(lo), 64'hFFFF_FFFE);
        check_val("sub_zero", 64'(zero), 64'd0);

        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, lat);
        check_val("slt_neg", 64'(lo), 64'd1);
        run_op(OP_SLT, 32'h1, 32'hFFFF_FFFF, lat);
        check_val("slt_pos", 64'(lo), 64'd0);
        run_op(OP_XOR, 32'hA5A5, 32'hFFFF, lat);
        check_val("xor", {hi, lo}, 64'h5A5A);
        run_op(OP_OR, 32'hF0, 32'h0F, lat);
        check_val("or", {hi, lo}, 64'hFF);

        run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check_val("mul_lat", 64'(lat), 64'd33);
        check_val("mul_busy_hold", 64'(bad_busy), 64'd0);
        check_val("mul_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        check_val("mul_dz", 64'(dz), 64'd0);
        run_op(OP_MULU, 32'd12345, 32'd100, lat);
        check_val("mul_small", {hi, lo}, 64'd1234500);

        run_op(OP_DIVU, 32'd100, 32'd7, lat);
`ifdef ALU_MC_DIV_EN
        check_val("div_lat", 64'(lat), 64'd33);
        check_val("div_busy_hold", 64'(bad_busy), 64'd0);
        check_val("div_result", {hi, lo}, {32'd2, 32'd14});
        check_val("div_dz", 64'(dz), 64'd0);
`else
        check_val("div_lat", 64'(lat), 64'd1);
        check_val("div_result", {hi, lo}, 64'd0);
        check_val("div_dz", 64'(dz), 64'd1);
`endif
        run_op(OP_DIVU, 32'd1234, 32'd0, lat);
        check_val("dz_lat", 64'(lat), 64'd1);
        check_val("dz_flag", 64'(dz), 64'd1);
`ifdef ALU_MC_DIV_EN
        check_val("dz_result", {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
`else
        check_val("dz_result", {hi, lo}, 64'd0);
`endif
        run_op(OP_ADD, 32'd3, 32'd4, lat);
        check_val("dz_clear", 64'({dz, lo}), 64'd7);

        // Backpressure: result must hold while the consumer stalls.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        run_op(OP_AND, 32'hF0F0, 32'hFF00, lat);
        check_val("and_lo", 64'(lo), 64'hF000);
        flag = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (lo !== 32'hF000 || out_valid !== 1'b1 || in_ready !== 1'b0) flag = 1'b0;
        end
        check_val("stall_stable", 64'(flag), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = OP_OR;
        a = 32'd1;
        b = 32'd2;
        #1;
        check_val("done_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("b2b_valid", 64'(out_valid), 64'd1);
        check_val("b2b_lo", 64'(lo), 64'd3);

        // Accept of an iterative op from DONE drops out_valid.
        out_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = OP_MULU;
        a = 32'd2;
        b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("b2b_mul_state", 64'({out_valid, busy}), 64'b01);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("b2b_mul_lat", 64'(lat), 64'd33);
        check_val("b2b_mul_res", {hi, lo}, 64'd6);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_MULU;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_hs", 64'({in_ready, out_valid, busy}), 64'b100);
        check_val("arst_lo_hi", {hi, lo}, 64'd0);
        check_val("arst_zero_dz", 64'({zero, dz}), 64'b10);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) flag = 1'b1;
        end
        check_val("arst_no_stray", 64'(flag), 64'd0);
        check_val("arst_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
